piso_serializer: RTL and testbench

Parallel-in, serial-out stage that sits directly upstream of the 101 sequence detector and drives its serial data_in.
- Accepts WIDTH-bit words through a valid/ready handshake.
- Emits one bit per clock, with a qualifying valid flag and a last-bit marker.
- Supports gap-free back-to-back words, so the downstream detector sees a contiguous bit stream.

---
 rtl/piso_serializer_pkg.sv | 16 +
 rtl/piso_serializer.sv | 83 ++++++++
 tb/tb_piso_serializer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in, serial-out stage that feeds the
// 101 sequence detector: the two-state FSM encoding and the bit-counter width.
package piso_pkg;

  // IDLE: no word in flight. SHIFT: a word is being shifted out.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Width of a counter that counts 0..width-1. Kept at 1 or more bits.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer. It takes WIDTH-bit words over a
// valid/ready handshake and emits one bit per clock. serial_valid qualifies
// each bit and last_bit marks the final bit of a word. Words can follow each
// other with no gap, so the detector downstream sees a contiguous bit stream.
//
// Handshake: a word transfers at a rising edge where load_valid && load_ready
// && !rst. load_ready is decoded from registers only. It never depends on
// load_valid or par_in. par_in is sampled only on that edge. Upstream holds
// load_valid and par_in until it sees the transfer.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] par_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last_bit
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // FSM state is a plain named signal so that checkers can bind to it.
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic             at_last;
  logic             handshake;
  logic             head_bit;
  logic [WIDTH-1:0] shifted;

  assign at_last    = (state == S_SHIFT) && (cnt == LAST);
  assign load_ready = (state == S_IDLE) || at_last;
  assign handshake  = load_valid && load_ready;

  // Output end of the shift register, and the register after one shift
  // toward that end with a 0 shifted in behind.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_bit = shreg[WIDTH-1];
      assign shifted  = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign head_bit = shreg[0];
      assign shifted  = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  // The idle line is forced low so the detector never sees a false '1'.
  assign serial_out   = (state == S_SHIFT) && head_bit;
  assign serial_valid = (state == S_SHIFT);
  assign last_bit     = at_last;

  // FSM, shift register and bit counter. Reset wins over a same-cycle load.
  // A load on the last bit of a word keeps SHIFT, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (handshake) begin
      state <= S_SHIFT;
      shreg <= par_in;
      cnt   <= '0;
    end else if (state == S_SHIFT) begin
      if (at_last) begin
        state <= S_IDLE;
        shreg <= '0;
        cnt   <= '0;
      end else begin
        shreg <= shifted;
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer. Three instances cover the main
// configuration (WIDTH=8, MSB first), LSB-first order, and a narrow WIDTH=3.
// The main instance is checked against a fixed table, then against a bit-queue
// reference model, with directed sequences followed by random traffic.
module tb_piso_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT: WIDTH=8, MSB_FIRST=1
  logic       lv0 = 1'b0;
  logic       rdy0;
  logic [7:0] par0 = 8'h00;
  logic       so0, sv0, lb0;

  // LSB-first DUT: WIDTH=8, MSB_FIRST=0
  logic       lv1 = 1'b0;
  logic       rdy1;
  logic [7:0] par1 = 8'h00;
  logic       so1, sv1, lb1;

  // narrow DUT: WIDTH=3, MSB_FIRST=1
  logic       lv2 = 1'b0;
  logic       rdy2;
  logic [2:0] par2 = 3'b000;
  logic       so2, sv2, lb2;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(rdy0), .par_in(par0),
    .serial_out(so0), .serial_valid(sv0), .last_bit(lb0));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy1), .par_in(par1),
    .serial_out(so1), .serial_valid(sv1), .last_bit(lb1));

  piso_serializer #(.WIDTH(3), .MSB_FIRST(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(rdy2), .par_in(par2),
    .serial_out(so2), .serial_valid(sv2), .last_bit(lb2));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model for the main DUT: a queue of bits still to be emitted.
  // Its head is the bit on the line now. A word is accepted when at most one
  // bit is left, because that bit leaves at the same edge.
  logic exp_q[$];

  function automatic void model_edge(input logic r, input logic lv,
                                     input logic [7:0] p);
    logic accept;
    if (r) begin
      exp_q.delete();
    end else begin
      accept = lv && (exp_q.size() <= 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (accept)
        for (int k = 0; k < 8; k++) exp_q.push_back(p[7-k]);
    end
  endfunction

  function automatic void check_model(input string tag);
    logic e_valid;
    e_valid = (exp_q.size() > 0);
    chk({tag, ".serial_valid"}, 32'(sv0), 32'(e_valid));
    chk({tag, ".serial_out"},   32'(so0), 32'(e_valid ? exp_q[0] : 1'b0));
    chk({tag, ".last_bit"},     32'(lb0), 32'(exp_q.size() == 1));
    chk({tag, ".load_ready"},   32'(rdy0), 32'(exp_q.size() <= 1));
  endfunction

  // ---------------- driver tasks ----------------
  // Drive the main DUT for one cycle, advance the model, and check after the edge.
  task automatic step(input string tag, input logic r, input logic lv,
                      input logic [7:0] p);
    rst  = r;
    lv0  = lv;
    par0 = p;
    @(posedge clk);
    model_edge(r, lv, p);
    #1;
    check_model(tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       r;
    logic       lv;
    logic [7:0] par;
    logic       e_out;
    logic       e_valid;
    logic       e_last;
    logic       e_ready;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic r, input logic lv, input logic [7:0] p,
                              input logic eo, input logic ev, input logic el,
                              input logic er);
    vec_t v;
    v.r = r; v.lv = lv; v.par = p;
    v.e_out = eo; v.e_valid = ev; v.e_last = el; v.e_ready = er;
    return v;
  endfunction

  initial begin
    // reset held with a word offered: nothing is accepted
    vt[0]  = mk(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[1]  = mk(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    // 8'hA5 accepted from IDLE: bits 1,0,1,0,0,1,0,1
    vt[2]  = mk(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    vt[3]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[4]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    vt[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[7]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    vt[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[9]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    // back to idle: line low
    vt[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[11] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // a load offered while the line is low under reset is ignored
    vt[12] = mk(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[13] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] w;
    #1;

    // table-driven vectors on the main DUT
    for (int i = 0; i < 14; i++) begin
      rst  = vt[i].r;
      lv0  = vt[i].lv;
      par0 = vt[i].par;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.serial_out", i),   32'(so0),  32'(vt[i].e_out));
      chk($sformatf("tbl%0d.serial_valid", i), 32'(sv0),  32'(vt[i].e_valid));
      chk($sformatf("tbl%0d.last_bit", i),     32'(lb0),  32'(vt[i].e_last));
      chk($sformatf("tbl%0d.load_ready", i),   32'(rdy0), 32'(vt[i].e_ready));
    end

    // model-checked sequences start from a known reset
    step("rst", 1'b1, 1'b0, 8'h00);

    // back-to-back AA then 55 with load_valid held high: 16 contiguous bits
    for (int i = 0; i < 8; i++)  step("b2b", 1'b0, 1'b1, 8'hAA);
    for (int i = 0; i < 8; i++)  step("b2b", 1'b0, 1'b1, 8'h55);
    step("b2b_end", 1'b0, 1'b0, 8'h00);
    step("b2b_idle", 1'b0, 1'b0, 8'h00);

    // busy ignore: 8'h00 pulsed on load_valid during bits 2..6 of 8'hFF
    step("busy_ld", 1'b0, 1'b1, 8'hFF);
    step("busy", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step("busy", 1'b0, i[0], 8'h00);
    step("busy", 1'b0, 1'b0, 8'h00);
    step("busy_acc", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) step("busy_tail", 1'b0, 1'b0, 8'h00);

    // reset mid-word, then a fresh 8'h3C serializes from its first bit
    step("mid_ld", 1'b0, 1'b1, 8'hA5);
    step("mid", 1'b0, 1'b0, 8'h00);
    step("mid", 1'b0, 1'b0, 8'h00);
    step("mid_rst", 1'b1, 1'b0, 8'h00);
    step("mid_new", 1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 9; i++) step("mid_tail", 1'b0, 1'b0, 8'h00);

    // random traffic, with an occasional reset
    for (int i = 0; i < 400; i++) begin
      w = 8'($urandom_range(0, 255));
      step("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), w);
    end
    step("rand_rst", 1'b1, 1'b0, 8'h00);
    rst = 1'b0;
    lv0 = 1'b0;

    // LSB first: 8'h01 -> 1 then seven 0s
    lv1  = 1'b1;
    par1 = 8'h01;
    @(posedge clk);
    #1;
    lv1  = 1'b0;
    par1 = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("lsb.bit%0d", k),   32'(so1), 32'(k == 0));
      chk($sformatf("lsb.valid%0d", k), 32'(sv1), 32'(1));
      chk($sformatf("lsb.last%0d", k),  32'(lb1), 32'(k == 7));
      @(posedge clk);
      #1;
    end
    chk("lsb.idle_valid", 32'(sv1), 32'(0));
    chk("lsb.idle_out",   32'(so1), 32'(0));

    // WIDTH=3: 3'b101 -> 1,0,1 with last_bit on the third bit
    lv2  = 1'b1;
    par2 = 3'b101;
    @(posedge clk);
    #1;
    lv2  = 1'b0;
    par2 = 3'b000;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w3.bit%0d", k),   32'(so2), 32'(k != 1));
      chk($sformatf("w3.valid%0d", k), 32'(sv2), 32'(1));
      chk($sformatf("w3.last%0d", k),  32'(lb2), 32'(k == 2));
      chk($sformatf("w3.ready%0d", k), 32'(rdy2), 32'(k == 2));
      @(posedge clk);
      #1;
    end
    chk("w3.idle_valid", 32'(sv2), 32'(0));
    chk("w3.idle_ready", 32'(rdy2), 32'(1));

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
